// File: rtl/instr_wb_master_if.sv
// Request/response and Wishbone B4 pipelined bus bundle
// used by the instrumented Wishbone master.
interface instr_wb_master_if;

    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stall_i;

    logic        req_i;
    logic        req_we_i;
    logic [31:0] req_adr_i;
    logic [31:0] req_dat_i;
    logic [3:0]  req_sel_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
        output wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_stall_i,
        input  req_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o,
        input  wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_stall_i,
        output req_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o
    );

endinterface

// File: rtl/instr_wb_master.sv
// Single-beat Wishbone B4 pipelined master driven by a test sequence.
// Optional bus timeout: define INSTR_WB_MASTER_TIMEOUT_EN.
module instr_wb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    instr_wb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ACK
    } state_t;

    state_t      state;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        ack_ok;
    logic        tmo;

    // An ack only counts once the strobe is (or is being) accepted.
    always_comb begin
        ack_ok = 1'b0;
        unique case (state)
            REQUEST:  ack_ok = bus.wb_ack_i & ~bus.wb_stall_i;
            WAIT_ACK: ack_ok = bus.wb_ack_i;
            default:  ack_ok = 1'b0;
        endcase
    end

`ifdef INSTR_WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;
    logic        rsp_err;

    always_comb begin
        tmo = (state != IDLE) && !ack_ok && (cnt == TMO_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= 16'h0;
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= 1'b0;
            if (state == IDLE) begin
                cnt <= 16'h0;
            end else if (!ack_ok) begin
                cnt <= cnt + 16'h1;
                rsp_err <= tmo;
            end
        end
    end

    assign bus.rsp_err_o = rsp_err;
`else
    always_comb begin
        tmo = 1'b0;
    end

    assign bus.rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            adr       <= 32'h0;
            dat       <= 32'h0;
            we        <= 1'b0;
            sel       <= 4'h0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            ready     <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        adr   <= bus.req_adr_i;
                        dat   <= bus.req_dat_i;
                        we    <= bus.req_we_i;
                        sel   <= bus.req_sel_i;
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        ready <= 1'b0;
                        state <= REQUEST;
                    end
                end
                REQUEST, WAIT_ACK: begin
                    if (ack_ok) begin
                        cyc       <= 1'b0;
                        stb       <= 1'b0;
                        ready     <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                        if (!we) begin
                            rsp_dat <= bus.wb_dat_i;
                        end
                    end else if (tmo) begin
                        cyc       <= 1'b0;
                        stb       <= 1'b0;
                        ready     <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end else if (state == REQUEST && !bus.wb_stall_i) begin
                        stb   <= 1'b0;
                        state <= WAIT_ACK;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wb_adr_o    = adr;
    assign bus.wb_dat_o    = dat;
    assign bus.wb_we_o     = we;
    assign bus.wb_sel_o    = sel;
    assign bus.wb_cyc_o    = cyc;
    assign bus.wb_stb_o    = stb;
    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_dat_o   = rsp_dat;

endmodule

// File: tb/tb_instr_wb_master.sv
// Directed bench for instr_wb_master with a response scoreboard.
// Timeout scenario runs when INSTR_WB_MASTER_TIMEOUT_EN is defined.
module tb_instr_wb_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    int n_rsp   = 0;
    int n_exp   = 0;

    logic [32:0] sb[$];
    logic [31:0] last_rd = 32'h0;

    instr_wb_master_if bus ();

    instr_wb_master #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard: every response pulse pops one expected {err, dat}.
    always @(negedge clk) begin
        if (bus.rsp_valid_o === 1'b1) begin
            logic [32:0] e;
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid_o), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_err", 32'(bus.rsp_err_o), 32'(e[32]));
                chk("rsp_dat", bus.rsp_dat_o, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic txn(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input int stalls, input int ack_dly,
                       input logic [31:0] rdat, input logic busy_req);
        chk("ready_before", 32'(bus.req_ready_o), 32'h1);
        bus.req_i     = 1'b1;
        bus.req_we_i  = we;
        bus.req_adr_i = adr;
        bus.req_dat_i = dat;
        bus.req_sel_i = sel;
        if (!we) last_rd = rdat;
        sb.push_back({1'b0, last_rd});
        n_exp++;
        @(negedge clk);
        bus.req_i     = busy_req;
        bus.req_adr_i = ~adr;
        bus.req_dat_i = ~dat;
        bus.req_sel_i = ~sel;
        chk("cyc_rise", 32'(bus.wb_cyc_o), 32'h1);
        chk("stb_rise", 32'(bus.wb_stb_o), 32'h1);
        chk("ready_busy", 32'(bus.req_ready_o), 32'h0);
        chk("adr", bus.wb_adr_o, adr);
        chk("we", 32'(bus.wb_we_o), 32'(we));
        bus.wb_stall_i = (stalls > 0);
        bus.wb_ack_i   = (stalls > 0);
        for (int i = 1; i <= stalls; i++) begin
            @(negedge clk);
            chk("stb_stall", 32'(bus.wb_stb_o), 32'h1);
            chk("adr_hold", bus.wb_adr_o, adr);
            chk("dat_hold", bus.wb_dat_o, dat);
            chk("sel_hold", 32'(bus.wb_sel_o), 32'(sel));
            if (i == stalls) bus.wb_stall_i = 1'b0;
        end
        bus.wb_ack_i = (ack_dly == 0);
        bus.wb_dat_i = rdat;
        if (ack_dly > 0) begin
            @(negedge clk);
            chk("stb_drop", 32'(bus.wb_stb_o), 32'h0);
            chk("cyc_wait", 32'(bus.wb_cyc_o), 32'h1);
            repeat (ack_dly - 1) begin
                @(negedge clk);
                chk("cyc_wait", 32'(bus.wb_cyc_o), 32'h1);
            end
            bus.wb_ack_i = 1'b1;
        end
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'h0BAD_0BAD;
        bus.req_i    = 1'b0;
        chk("cyc_end", 32'(bus.wb_cyc_o), 32'h0);
        chk("stb_end", 32'(bus.wb_stb_o), 32'h0);
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("ready_end", 32'(bus.req_ready_o), 32'h1);
        chk("rsp_dat_end", bus.rsp_dat_o, last_rd);
        chk("adr_retain", bus.wb_adr_o, adr);
    endtask

    initial begin
        bus.req_i      = 1'b0;
        bus.req_we_i   = 1'b0;
        bus.req_adr_i  = 32'h0;
        bus.req_dat_i  = 32'h0;
        bus.req_sel_i  = 4'h0;
        bus.wb_dat_i   = 32'h0;
        bus.wb_ack_i   = 1'b0;
        bus.wb_stall_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
        chk("rst_stb", 32'(bus.wb_stb_o), 32'h0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'h1);
        chk("rst_adr", bus.wb_adr_o, 32'h0);
        chk("rst_sel", 32'(bus.wb_sel_o), 32'h0);
        chk("rst_rsp_dat", bus.rsp_dat_o, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Ack in IDLE must not produce a response.
        bus.wb_ack_i = 1'b1;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        chk("idle_ack_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("idle_ack_cyc", 32'(bus.wb_cyc_o), 32'h0);

        txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("valid_pulse", 32'(bus.rsp_valid_o), 32'h0);

        // Write with three stall cycles; acks during stall are ignored.
        txn(1'b1, 32'h8, 32'h12345678, 4'h3, 3, 1, 32'h0, 1'b0);

        // Back-to-back, with req held high while busy.
        txn(1'b0, 32'h200, 32'h0, 4'hF, 1, 2, 32'hA5A5_5A5A, 1'b1);
        txn(1'b0, 32'h204, 32'h0, 4'h1, 0, 0, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);

        // Reset while waiting for ack drops the transfer.
        bus.req_i     = 1'b1;
        bus.req_we_i  = 1'b0;
        bus.req_adr_i = 32'h300;
        bus.req_sel_i = 4'hF;
        @(negedge clk);
        bus.req_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_cyc", 32'(bus.wb_cyc_o), 32'h1);
        chk("pre_rst_stb", 32'(bus.wb_stb_o), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready_o), 32'h1);
        chk("mid_rst_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("mid_rst_dat", bus.rsp_dat_o, 32'h0);
        last_rd = 32'h0;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h1111_2222;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        chk("late_ack_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("late_ack_cyc", 32'(bus.wb_cyc_o), 32'h0);

`ifdef INSTR_WB_MASTER_TIMEOUT_EN
        txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 1, 32'h7777_0001, 1'b0);
        @(negedge clk);
        bus.req_i     = 1'b1;
        bus.req_we_i  = 1'b0;
        bus.req_adr_i = 32'h44;
        sb.push_back({1'b1, last_rd});
        n_exp++;
        @(negedge clk);
        bus.req_i = 1'b0;
        begin
            int hi = 0;
            while (bus.wb_cyc_o === 1'b1 && hi < 40) begin
                hi++;
                @(negedge clk);
            end
            chk("tmo_cycles", 32'(hi), 32'd8);
        end
        chk("tmo_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("tmo_err", 32'(bus.rsp_err_o), 32'h1);
        chk("tmo_dat", bus.rsp_dat_o, last_rd);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        chk("rsp_count", 32'(n_rsp), 32'(n_exp));
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_wb_master.md
Name:
instr_wb_master

Overview:
- Instrumented Wishbone B4 pipelined master for driving DUT slave ports from a testbench.
- Counterpart of the instrumented slave: a test sequence posts single read/write requests on a simple request/response interface.
- The block runs a compliant single-beat cycle (CYC/STB/STALL/ACK) and returns the read data, or an error when the optional timeout is enabled.
- Sits between the C++ test driver and the DUT's Wishbone slave port.

Parameters:
- TIMEOUT_CYCLES, 16: cycles with cyc_o high and no ack before abort. Used only when the optional feature is compiled in; legal range 2..65535.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte select.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- wb_cyc_o  out  1  bus cycle.
- wb_stall_i  in  1  slave stall.
- req_i  in  1  request strobe from the instrumentation side.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  32  request address.
- req_dat_i  in  32  request write data.
- req_sel_i  in  4  request byte select.
- req_ready_o  out  1  master idle; a request is accepted this cycle.
- rsp_valid_o  out  1  one-cycle pulse: transaction finished.
- rsp_dat_o  out  32  last read data captured.
- rsp_err_o  out  1  qualifies rsp_valid_o; 1 = aborted by timeout.

Behaviour:
- Reset:
  - Applied at the next rising edge with rst_i=1, in any state, including mid-transfer.
  - State goes to IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o and rsp_err_o go to 0.
  - wb_adr_o, wb_dat_o and rsp_dat_o go to 32'h0; wb_sel_o goes to 4'h0.
  - req_ready_o=1 in the first cycle after reset.
  - Any transfer in flight is dropped with no response.
- States: IDLE, REQUEST, WAIT_ACK.
- IDLE:
  - req_ready_o=1, cyc_o=0, stb_o=0.
  - On an edge with req_i=1, the block registers adr/dat/we/sel onto the wb_* outputs and moves to REQUEST.
  - cyc_o and stb_o are high from the cycle after acceptance (latency 1).
- REQUEST:
  - cyc_o=1, stb_o=1. adr/dat/we/sel are held stable while wb_stall_i=1.
  - On an edge with wb_stall_i=0 the strobe is accepted: stb_o=0 from the next cycle and the state moves to WAIT_ACK.
  - If wb_ack_i=1 on that same accepting edge, the transaction completes directly, as in WAIT_ACK.
  - An ack arriving while stalled is ignored.
- WAIT_ACK:
  - cyc_o=1, stb_o=0.
  - On an edge with wb_ack_i=1:
    - Next cycle: cyc_o=0, rsp_valid_o=1, rsp_err_o=0, state IDLE.
    - For reads, rsp_dat_o is loaded from wb_dat_i on that edge.
    - Writes leave rsp_dat_o unchanged.
- rsp_valid_o:
  - High exactly one cycle per transaction.
  - req_ready_o is also 1 in that cycle, so back-to-back requests are allowed: turnaround is one idle cyc_o=0 cycle between transactions.
- Request handling:
  - req_i while req_ready_o=0 is ignored and not queued.
  - Inputs are sampled only on the accepting edge.
- wb_ack_i in IDLE is ignored.
- wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o retain their last values after cycle end.
- One outstanding transfer at most.

Optional Feature:
- Macro: INSTR_WB_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQUEST and increments every cycle in REQUEST/WAIT_ACK without an ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack on that edge:
    - Next cycle: cyc_o=0, stb_o=0, state IDLE.
    - rsp_valid_o=1 and rsp_err_o=1 for one cycle.
    - rsp_dat_o is unchanged.
  - An ack on the same edge as the timeout wins: normal completion, rsp_err_o=0.
- Undefined:
  - No counter; the master waits indefinitely.
  - rsp_err_o is tied to 0.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then single read: req_i=1, we=0, adr=32'h100, sel=4'hF; slave stall=0, ack one cycle after stb with dat=32'hDEADBEEF -> cyc_o/stb_o high at cycle+1, stb 1 cycle, rsp_valid pulse with rsp_dat_o=32'hDEADBEEF, rsp_err_o=0.
- Write with stall 3 cycles: adr=32'h8, dat=32'h12345678, sel=4'h3 -> stb_o high 4 cycles with stable adr/dat/sel; ack -> rsp_valid pulse; rsp_dat_o keeps the previous read value.
- Back-to-back: second request asserted in the rsp_valid_o cycle of the first -> accepted; exactly one cyc_o=0 cycle between the two bus cycles; req_i during the busy period is ignored (only 2 responses).
- Ack on the accepting edge (stall=0, ack=1 same cycle as stb) -> completion, stb_o for 1 cycle, rsp_valid pulse next cycle.
- rst_i=1 while in WAIT_ACK -> cyc_o=0 next cycle, no rsp_valid_o, req_ready_o=1; a later ack is ignored.
- With INSTR_WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> cyc_o drops 8 cycles after rising, rsp_valid_o=1 with rsp_err_o=1, rsp_dat_o unchanged.
